// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// the response FSM state type and width/alignment helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Half needs offset[0]=0, word needs offset=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Stores only have signed encodings; loads also allow the unsigned ones.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        if (we) return funct3 > F3_W;
        return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

    function automatic logic [3:0] byte_strobe(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << offset;
            2'b01:   return offset[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Load lane select with sign/zero extension, and store data replication
// across the byte lanes so the strobe alone picks what gets written.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed lane(s) and extend according to funct3.
    always_comb begin
        case (offset)
            2'd0:    sel_byte = rword[7:0];
            2'd1:    sel_byte = rword[15:8];
            2'd2:    sel_byte = rword[23:16];
            default: sel_byte = rword[31:24];
        endcase
        sel_half = offset[1] ? rword[31:16] : rword[15:0];
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'd0, sel_half};
            F3_W:    load_data = rword;
            default: load_data = 32'd0;
        endcase
    end

    // Replicate right-aligned store data into every candidate lane.
    always_comb begin
        case (funct3[1:0])
            2'b00:   store_word = {4{wdata[7:0]}};
            2'b01:   store_word = {2{wdata[15:0]}};
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ram.sv
// Byte-addressed, word-organised data RAM with RISC-V load/store widths,
// valid/ready handshakes and programmable load latency.
// Optional per-lane even parity when DMEM_PARITY_EN is defined.
module dmem_lsu_ram
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned WAIT_CYC   = 1,
    parameter int unsigned CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [31:0]       mem [DEPTH];
    state_t            state;
    logic [3:0]        cnt;
    logic [2:0]        lat_f3;
    logic [ADDR_W-1:0] lat_addr;

    logic [2:0]        sel_f3;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       rd_word, ld_data, st_word;
    logic [3:0]        st_strb;
    logic              req_bad, do_store, par_err;

    // In IDLE the live request drives the datapath (stores, zero-wait loads);
    // afterwards the latched load address/funct3 take over.
    always_comb begin
        sel_f3   = (state == IDLE) ? req_funct3 : lat_f3;
        sel_addr = (state == IDLE) ? req_addr   : lat_addr;
    end

    assign rd_word   = mem[sel_addr[ADDR_W-1:2]];
    assign req_bad   = is_misaligned(req_funct3, req_addr[1:0]) | is_illegal(req_we, req_funct3);
    assign do_store  = (state == IDLE) && req_valid && req_we && !req_bad;
    assign st_strb   = byte_strobe(req_funct3, req_addr[1:0]);
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    dmem_lane_align u_align (
        .funct3     (sel_f3),
        .offset     (sel_addr[1:0]),
        .rword      (rd_word),
        .wdata      (req_wdata),
        .load_data  (ld_data),
        .store_word (st_word)
    );

`ifdef DMEM_PARITY_EN
    logic [3:0] par_mem [DEPTH];
    logic [3:0] rd_par, st_par, ld_strb;

    // Even parity per lane; only the lanes actually being loaded are checked.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            rd_par[l] = ^rd_word[8*l +: 8];
            st_par[l] = ^st_word[8*l +: 8];
        end
        ld_strb = byte_strobe(sel_f3, sel_addr[1:0]);
        par_err = |(ld_strb & (par_mem[sel_addr[ADDR_W-1:2]] ^ rd_par));
    end
`else
    assign par_err = 1'b0;
`endif

    // Array write port: strobed lanes written on the accept edge of a store.
    if (CLR_ON_RST != 0) begin : g_clr
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    mem[i] <= '0;
`ifdef DMEM_PARITY_EN
                    par_mem[i] <= '0;
`endif
                end
            end else if (do_store) begin
                for (int l = 0; l < 4; l++) begin
                    if (st_strb[l]) begin
                        mem[req_addr[ADDR_W-1:2]][8*l +: 8] <= st_word[8*l +: 8];
`ifdef DMEM_PARITY_EN
                        par_mem[req_addr[ADDR_W-1:2]][l] <= st_par[l];
`endif
                    end
                end
            end
        end
    end else begin : g_keep
        always_ff @(posedge clk) begin
            if (do_store) begin
                for (int l = 0; l < 4; l++) begin
                    if (st_strb[l]) begin
                        mem[req_addr[ADDR_W-1:2]][8*l +: 8] <= st_word[8*l +: 8];
`ifdef DMEM_PARITY_EN
                        par_mem[req_addr[ADDR_W-1:2]][l] <= st_par[l];
`endif
                    end
                end
            end
        end
    end

    // Request/response FSM with registered response data and error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_f3    <= 3'd0;
            lat_addr  <= '0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_bad || req_we) begin
                            state     <= RESP;
                            rsp_rdata <= 32'd0;
                            rsp_err   <= req_bad;
                        end else begin
                            lat_f3   <= req_funct3;
                            lat_addr <= req_addr;
                            if (WAIT_CYC == 0) begin
                                state     <= RESP;
                                rsp_rdata <= ld_data;
                                rsp_err   <= par_err;
                            end else begin
                                state <= WAIT;
                                cnt   <= 4'(WAIT_CYC - 1);
                            end
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_rdata <= ld_data;
                        rsp_err   <= par_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ram.sv
// Randomized bench for dmem_lsu_ram against a byte-array reference model.
module tb_dmem_lsu_ram;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned WAIT_CYC = 1;
    localparam int          NBYTES   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'd0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic [7:0]  ref_mem [NBYTES];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] got_rd;
    logic        got_err;

    dmem_lsu_ram #(
        .ADDR_W     (ADDR_W),
        .WAIT_CYC   (WAIT_CYC),
        .CLR_ON_RST (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference: little-endian byte memory, access rules straight from the ISA.
    task automatic ref_access(input bit we, input logic [2:0] f3, input int addr,
                              input logic [31:0] wdata, output logic [31:0] rd,
                              output logic err);
        int  nb;
        bit  legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        rd    = 32'd0;
        err   = 1'b0;
        if (!legal || (addr % nb) != 0) begin
            err = 1'b1;
            return;
        end
        for (int i = 0; i < nb; i++) begin
            if (we) ref_mem[addr + i] = wdata[8*i +: 8];
            else    rd = rd | (32'(ref_mem[addr + i]) << (8 * i));
        end
        if (!we && f3 == 3'd0 && rd[7])  rd = rd | 32'hFFFF_FF00;
        if (!we && f3 == 3'd1 && rd[15]) rd = rd | 32'hFFFF_0000;
    endtask

    // One full transaction: accept, latency, response, hold, release.
    task automatic do_req(input bit we, input logic [2:0] f3, input int addr,
                          input logic [31:0] wdata, input int hold, input bit force_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat, exp_lat;
        ref_access(we, f3, addr, wdata, exp_rd, exp_err);
        exp_lat = (!we && !exp_err) ? int'(WAIT_CYC) + 1 : 1;
        if (force_err) exp_err = 1'b1;
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = ADDR_W'(addr);
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!rsp_valid) begin
            check_eq("rsp_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
        check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
        check_eq("req_ready_busy", 32'(req_ready), 32'd0);
        got_rd  = rsp_rdata;
        got_err = rsp_err;
        for (int h = 0; h < hold; h++) begin
            // A stray store request while busy must be ignored.
            if (h == 0) begin
                req_valid  = 1'b1;
                req_we     = 1'b1;
                req_funct3 = 3'd2;
                req_addr   = ADDR_W'($urandom_range(0, 63) & 32'hFFFC);
                req_wdata  = $urandom;
            end
            @(posedge clk);
            #1 req_valid = 1'b0;
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_rdata", rsp_rdata, exp_rd);
            check_eq("hold_err", 32'(rsp_err), 32'(exp_err));
            check_eq("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check_eq("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'd0;
        #1;
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_err", 32'(rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("rst_ready", 32'(req_ready), 32'd1);

        // Directed sequence
        do_req(1, 3'd2, 'h004, 32'hDEADBEEF, 0, 0);
        do_req(0, 3'd2, 'h004, 32'd0, 0, 0);
        check_eq("lw_deadbeef", got_rd, 32'hDEADBEEF);
        do_req(1, 3'd0, 'h005, 32'h00000080, 0, 0);
        do_req(0, 3'd0, 'h005, 32'd0, 0, 0);
        check_eq("lb_sign", got_rd, 32'hFFFFFF80);
        do_req(0, 3'd4, 'h005, 32'd0, 0, 0);
        check_eq("lbu_zero", got_rd, 32'h00000080);
        do_req(0, 3'd2, 'h004, 32'd0, 0, 0);
        check_eq("lw_merged", got_rd, 32'hDEAD80EF);
        do_req(1, 3'd1, 'h006, 32'h00001234, 0, 0);
        do_req(0, 3'd1, 'h006, 32'd0, 0, 0);
        check_eq("lh_pos", got_rd, 32'h00001234);
        do_req(0, 3'd1, 'h003, 32'd0, 0, 0);
        check_eq("lh_misaligned", 32'(got_err), 32'd1);
        do_req(1, 3'd2, 'h002, 32'hCAFEF00D, 0, 0);
        do_req(0, 3'd2, 'h004, 32'd0, 5, 0);
        check_eq("sw_mis_nowrite", got_rd, 32'h123480EF);
        do_req(0, 3'd3, 'h008, 32'd0, 1, 0);
        check_eq("ld_f3_3_err", 32'(got_err), 32'd1);
        do_req(1, 3'd4, 'h008, 32'h55555555, 0, 0);
        check_eq("st_f3_4_err", 32'(got_err), 32'd1);
        do_req(0, 3'd6, 'h008, 32'd0, 0, 0);
        do_req(0, 3'd2, 'h3FC, 32'd0, 0, 0);

`ifdef DMEM_PARITY_EN
        dut.par_mem[1][1] = ~dut.par_mem[1][1];
        do_req(0, 3'd0, 'h005, 32'd0, 0, 1);
        check_eq("parity_err", 32'(got_err), 32'd1);
        do_req(1, 3'd0, 'h005, 32'h00000080, 0, 0);
`endif

        // Reset while a load is waiting
        check_eq("pre_rst_ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = ADDR_W'(4);
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'd0;
        check_eq("midrst_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("midrst_ready", 32'(req_ready), 32'd1);
        do_req(0, 3'd2, 'h004, 32'd0, 0, 0);
        check_eq("lw_cleared", got_rd, 32'd0);

        // Reset while a response is being held
        do_req(1, 3'd2, 'h010, 32'h0BADF00D, 0, 0);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = ADDR_W'('h010);
        repeat (WAIT_CYC + 1) @(posedge clk);
        #1 req_valid = 1'b0;
        check_eq("resp_before_rst", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'd0;
        check_eq("rst_in_resp", 32'(rsp_valid), 32'd0);
        check_eq("rst_in_resp_rd", rsp_rdata, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic concentrated on a small window for frequent reuse
        for (int n = 0; n < 300; n++) begin
            int a;
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NBYTES - 1))
                                            : int'($urandom_range(0, 31));
            do_req(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                   int'($urandom_range(0, 3)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_lsu_ram.md
Name: dmem_lsu_ram

Overview:
Next-generation data memory for the RISC-V core: a byte-addressed, word-organised RAM with RISC-V load/store width handling. Supports byte, half and word accesses, with sign or zero extension on loads.
- Uses a valid/ready request and response handshake.
- Read latency is programmable, so it can model slower memories.
- Misaligned and illegal accesses are detected.
- Sits between the core's MEM stage and the data address space; replaces the plain word RAM.

Parameters:
ADDR_W, 10, byte-address width; depth = 2**(ADDR_W-2) 32-bit words
WAIT_CYC, 1, extra wait cycles before load data is returned (0..15)
CLR_ON_RST, 1, 1 = array (and parity) cleared on reset; 0 = contents retained

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 of the load/store
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (rs2)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or illegal access (or parity error, see below)

Behaviour:
- Reset (rst_n low, async): state=IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. If CLR_ON_RST=1, all words are cleared to 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1; a request is accepted on an edge where req_valid=1.
- Legality check: half needs addr[0]=0; word needs addr[1:0]=0.
- Legal load funct3: 0,1,2,4,5. Legal store funct3: 0,1,2. Anything else is illegal.
- Illegal or misaligned request: no write; next state RESP with rsp_err=1, rsp_rdata=0.
- Legal store: the byte lanes selected by addr[1:0] and width are written on the accept edge.
  - SB writes req_wdata[7:0] into lane addr[1:0].
  - SH writes [15:0] into lanes {addr[1],0} and {addr[1],1}.
  - SW writes all 4 lanes.
  - Unselected lanes keep their contents. Next state RESP, rsp_err=0, rsp_rdata=0.
- Legal load: addr and funct3 are latched.
  - WAIT_CYC=0: go directly to RESP.
  - Otherwise go to WAIT with counter=WAIT_CYC-1.
- WAIT: counter decrements each cycle; leave for RESP when counter==0.
- Load data is captured from the array on the edge entering RESP. Lane select uses the latched addr[1:0].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Load latency: rsp_valid rises WAIT_CYC+1 cycles after the accept edge.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1; then go to IDLE and drop rsp_valid.
- Back-to-back requests see a one-cycle bubble: req_ready is low in WAIT and RESP.
- Address wrap: only addr[ADDR_W-1:2] indexes the array; no out-of-range condition exists.
- Reset mid-operation aborts the pending response. A store already written stays written (unless CLR_ON_RST=1).
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro DMEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane and written together with the data lane.
  - On load, parity is checked only on the lanes being read.
  - A mismatch sets rsp_err=1; rsp_rdata still carries the extended data.
  - Parity bits are cleared with the array on reset.
- Undefined: no parity storage; rsp_err reports misaligned and illegal accesses only.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - The FSM state enum {IDLE, WAIT, RESP}.
  - Function is_misaligned(funct3, addr[1:0]).
  - Function byte_strobe(funct3, addr[1:0]) returning 4 bits.
- One sub-module, dmem_lane_align: combinational load lane select and sign/zero extension, plus store data replication to lanes.

Test Plan:
- SW addr=0x004 data=0xDEADBEEF, then LW 0x004 with WAIT_CYC=1 -> rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- SB 0x005 data=0x80, then LB 0x005 -> 0xFFFFFF80. LBU 0x005 -> 0x00000080. LW 0x004 -> 0xDEAD80EF.
- SH 0x006 data=0x1234, then LH 0x006 -> 0x00001234. Then LH 0x003 -> rsp_err=1, rsp_rdata=0. SW 0x002 -> rsp_err=1 and memory unchanged.
- Load with rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0. A req_valid pulse during this time is ignored.
- Assert rst_n low during WAIT of a load -> rsp_valid=0 immediately. After release, req_ready=1. With CLR_ON_RST=1, LW 0x004 returns 0.
- Illegal funct3=3 load and funct3=4 store -> rsp_err=1. With DMEM_PARITY_EN, a forced parity-bit flip on lane 1 plus LB 0x005 -> rsp_err=1.
